alu16_mul_seq: RTL and testbench

ALU16_MUL_SEQ -- requirements
Module: alu16_mul_seq

---
 rtl/alu16_mul_seq.sv | 63 ++++++
 tb/tb_alu16_mul_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_mul_seq.sv
// alu16_mul_seq: sequential 16x16 unsigned shift-add multiplier that does its additions on an external ALU
module alu16_mul_seq #(
  parameter logic [2:0] OP_ADD = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic        alu_ainvert,
  output logic        alu_bnegate,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_cout
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state;
  logic [15:0] mcand;
  logic [15:0] mq;
  logic [15:0] acc;
  logic [3:0]  cnt;
  assign in_ready    = state == IDLE;
  assign out_valid   = state == DONE;
  assign out_p       = {acc, mq};
  assign alu_a       = state == RUN ? acc : 16'h0000;
  assign alu_b       = (state == RUN && mq[0]) ? mcand : 16'h0000;
  assign alu_op      = OP_ADD;
  assign alu_cin     = 1'b0;
  assign alu_ainvert = 1'b0;
  assign alu_bnegate = 1'b0;
  // Capture operands in IDLE, shift the ALU sum into {acc, mq} for 16 RUN cycles, hold the product in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      mq    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == IDLE && in_valid) begin
      mcand <= in_a;
      mq    <= in_b;
      acc   <= '0;
      cnt   <= '0;
      state <= RUN;
    end else if (state == RUN) begin
      acc   <= {alu_cout, alu_result[15:1]};
      mq    <= {alu_result[0], mq[15:1]};
      cnt   <= cnt + 4'd1;
      state <= cnt == 4'd15 ? DONE : RUN;
    end else if (state == DONE ? out_ready : state != IDLE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu16_mul_seq.sv
// tb_alu16_mul_seq: directed checks of alu16_mul_seq driving a behavioural adder ALU
module tb_alu16_mul_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_p;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic        alu_ainvert;
  logic        alu_bnegate;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_cout;
  int checks = 0;
  int errors = 0;

  alu16_mul_seq #(.OP_ADD(3'b010)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_ainvert(alu_ainvert), .alu_bnegate(alu_bnegate), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: op 010 adds, anything else ANDs so a wrong op code corrupts the product
  always_comb begin
    logic [15:0] ae;
    logic [15:0] be;
    logic [16:0] sum;
    ae = alu_ainvert ? ~alu_a : alu_a;
    be = alu_bnegate ? ~alu_b : alu_b;
    sum = {1'b0, ae} + {1'b0, be} + {16'b0, alu_cin};
    alu_result = alu_op == 3'b010 ? sum[15:0] : (ae & be);
    alu_cout = alu_op == 3'b010 ? sum[16] : 1'b0;
  end

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 32'h0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b out_p=%h, want 1 0 0", in_ready, out_valid, out_p);
    end
    checks++;
    if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 3'b010 || {alu_cin, alu_ainvert, alu_bnegate} !== 3'b000) begin
      errors++;
      $display("FAIL reset_alu: a=%h b=%h op=%b ctl=%b, want 0 0 010 000", alu_a, alu_b, alu_op, {alu_cin, alu_ainvert, alu_bnegate});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_a !== 16'h0) begin
      errors++;
      $display("FAIL idle_hold: in_ready=%b out_valid=%b alu_a=%h, want 1 0 0", in_ready, out_valid, alu_a);
    end
  endtask

  // Issue one operation at a negedge, wait for out_valid, check latency and product, optionally consume it
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp, input string nm,
                        input bit consume, output bit saw_cout, output bit saw_bnz);
    int lat;
    bit bad_ctl;
    saw_cout = 1'b0;
    saw_bnz = 1'b0;
    bad_ctl = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: in_ready=%b, want 1", nm, in_ready);
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      in_a = ~a;
      in_b = ~b;
      lat++;
      if (!out_valid) begin
        if (alu_cout) saw_cout = 1'b1;
        if (alu_b !== 16'h0) saw_bnz = 1'b1;
        if (alu_op !== 3'b010 || alu_cin || alu_ainvert || alu_bnegate || in_ready) bad_ctl = 1'b1;
      end
    end while (!out_valid && lat < 40);
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want 17", nm, lat);
    end
    checks++;
    if (out_p !== exp) begin
      errors++;
      $display("FAIL %s_product: out_p=%h, want %h", nm, out_p, exp);
    end
    checks++;
    if (bad_ctl) begin
      errors++;
      $display("FAIL %s_run_ctl: ALU controls or in_ready wrong during RUN, want op=010 ctl=000 in_ready=0", nm);
    end
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_b !== 16'h0) begin
        errors++;
        $display("FAIL %s_back_idle: in_ready=%b out_valid=%b alu_b=%h, want 1 0 0", nm, in_ready, out_valid, alu_b);
      end
    end
  endtask

  task automatic test_basic();
    bit c;
    bit z;
    run_op(16'd3, 16'd5, 32'd15, "mul3x5", 1'b1, c, z);
  endtask

  task automatic test_max();
    bit c;
    bit z;
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "mulmax", 1'b1, c, z);
    checks++;
    if (c !== 1'b1) begin
      errors++;
      $display("FAIL mulmax_cout: alu_cout seen=%b, want 1", c);
    end
  endtask

  task automatic test_zero();
    bit c;
    bit z;
    run_op(16'h1234, 16'h0000, 32'h0, "zero_b", 1'b1, c, z);
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL zero_b_alu_b: nonzero alu_b seen=%b, want 0", z);
    end
    run_op(16'h0000, 16'hABCD, 32'h0, "zero_a", 1'b1, c, z);
  endtask

  task automatic test_hold();
    bit c;
    bit z;
    bit bad;
    run_op(16'h00FF, 16'h0101, 32'h0000FFFF, "hold", 1'b0, c, z);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 16'h5555;
      in_b = 16'h7777;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_p !== 32'h0000FFFF) bad = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_stable: out_valid=%b in_ready=%b out_p=%h, want 1 0 0000ffff", out_valid, in_ready, out_p);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b, want 1 0 (in_valid pulses ignored)", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit c;
    bit z;
    in_valid = 1'b1;
    in_a = 16'hBEEF;
    in_b = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 32'h0 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
      errors++;
      $display("FAIL midrst_state: in_ready=%b out_valid=%b out_p=%h alu_a=%h alu_b=%h, want 1 0 0 0 0",
               in_ready, out_valid, out_p, alu_a, alu_b);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'd7, 16'd9, 32'd63, "after_rst", 1'b1, c, z);
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [10] = '{16'h0100, 16'hFFFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h1234, 16'h00FF, 16'hAAAA, 16'h0002, 16'hFFFF};
    logic [15:0] vb [10] = '{16'h0100, 16'h0001, 16'h0002, 16'h0001, 16'h0002, 16'h0010, 16'h00FF, 16'h0003, 16'h8000, 16'h8000};
    logic [31:0] vp [10] = '{32'h00010000, 32'h0000FFFF, 32'h00010000, 32'h00000001, 32'h0001FFFE,
                             32'h00012340, 32'h0000FE01, 32'h0001FFFE, 32'h00010000, 32'h7FFF8000};
    bit c;
    bit z;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) run_op(va[i], vb[i], vp[i], $sformatf("b2b%0d", i), 1'b1, c, z);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      run_op(a, b, {16'h0, a} * {16'h0, b}, $sformatf("rnd%0d", i), 1'b1, c, z);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
